// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU UART front end: default widths, the legal
// ALU opcodes and the frame FSM state encoding.
package alu_defs;

  localparam int NB_DATA_DEF = 6;
  localparam int NB_OP_DEF   = 6;
  localparam int NB_BYTE_DEF = 8;

  localparam int OP_ADD = 'h20;
  localparam int OP_SUB = 'h22;
  localparam int OP_AND = 'h24;
  localparam int OP_OR  = 'h25;
  localparam int OP_XOR = 'h26;
  localparam int OP_SRA = 'h03;
  localparam int OP_SRL = 'h02;
  localparam int OP_NOR = 'h27;

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_CHECK,
    ST_COMPUTE,
    ST_SEND,
    ST_WAIT_TX
  } state_e;

  function automatic logic op_is_legal(input int op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_frontend_frame_timer.sv
// Inter-byte idle counter: cleared on demand, counts while enabled and flags
// expiry on the cycle that would bring it to TIMEOUT_CYC.
module frame_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = i_enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/alu_uart_frontend.sv
// UART-to-ALU front end: assembles A/B/OP frames, filters illegal opcodes,
// drops stalled frames and forwards the sign-extended ALU result to the TX.
module alu_uart_frontend
  import alu_defs::*;
#(
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int NB_OP       = NB_OP_DEF,
  parameter int NB_BYTE     = NB_BYTE_DEF,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic        [NB_BYTE-1:0] i_rx_data,
  input  logic                      i_rx_done,
  input  logic signed [NB_DATA:0]   i_alu_res,
  input  logic                      i_tx_done,
  output logic signed [NB_DATA-1:0] o_data_a,
  output logic signed [NB_DATA-1:0] o_data_b,
  output logic        [NB_OP-1:0]   o_op,
  output logic        [NB_BYTE-1:0] o_tx_data,
  output logic                      o_tx_start,
  output logic                      o_err,
  output logic                      o_busy
);

  function automatic logic [NB_BYTE-1:0] sext_res(input logic signed [NB_DATA:0] v);
    logic signed [NB_BYTE-1:0] t;
    t = v;
    return t;
  endfunction

  state_e state_q, state_d;

  logic [NB_DATA-1:0] a_sh_q, b_sh_q;
  logic [NB_OP-1:0]   op_sh_q;

  logic signed [NB_DATA-1:0] data_a_q, data_b_q;
  logic        [NB_OP-1:0]   op_q;
  logic        [NB_BYTE-1:0] tx_data_q;
  logic                      tx_start_q, err_q;

  logic op_legal, tmr_expire;
  logic cap_a, cap_b, cap_op, latch_ops, load_tx;
  logic start_d, err_d, tmr_clear, tmr_en;

  // Operand/opcode bytes only use their low bits.
  logic unused_rx_hi;
  assign unused_rx_hi = ^i_rx_data;

  assign op_legal = op_is_legal(int'(op_sh_q));

  frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (tmr_clear),
    .i_enable(tmr_en),
    .o_expire(tmr_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_A: if (i_rx_done) state_d = ST_WAIT_B;
      ST_WAIT_B: begin
        if (i_rx_done)       state_d = ST_WAIT_OP;
        else if (tmr_expire) state_d = ST_WAIT_A;
      end
      ST_WAIT_OP: begin
        if (i_rx_done)       state_d = ST_CHECK;
        else if (tmr_expire) state_d = ST_WAIT_A;
      end
      ST_CHECK:   state_d = op_legal ? ST_COMPUTE : ST_WAIT_A;
      ST_COMPUTE: state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) state_d = ST_WAIT_A;
      default:    state_d = ST_WAIT_A;
    endcase
  end

  always_comb begin
    cap_a     = (state_q == ST_WAIT_A)  && i_rx_done;
    cap_b     = (state_q == ST_WAIT_B)  && i_rx_done;
    cap_op    = (state_q == ST_WAIT_OP) && i_rx_done;
    latch_ops = (state_q == ST_CHECK) && op_legal;
    load_tx   = (state_q == ST_COMPUTE);
    start_d   = (state_q == ST_COMPUTE);
    tmr_en    = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    tmr_clear = (state_q == ST_WAIT_A) || cap_b || cap_op;
    err_d     = ((state_q == ST_CHECK) && !op_legal) ||
                (tmr_en && !i_rx_done && tmr_expire);
  end

  // Shadow bytes are pure data and are always rewritten before use.
  always_ff @(posedge i_clk) begin
    if (cap_a)  a_sh_q  <= i_rx_data[NB_DATA-1:0];
    if (cap_b)  b_sh_q  <= i_rx_data[NB_DATA-1:0];
    if (cap_op) op_sh_q <= i_rx_data[NB_OP-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (latch_ops) begin
        data_a_q <= a_sh_q;
        data_b_q <= b_sh_q;
        op_q     <= op_sh_q;
      end
      if (load_tx) tx_data_q <= sext_res(i_alu_res);
      tx_start_q <= start_d;
      err_q      <= err_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != ST_WAIT_A);

endmodule

// File: tb/tb_alu_uart_frontend.sv
// Directed and randomized bench for alu_uart_frontend with a behavioural ALU
// and a transaction-level reference model.
module tb_alu_uart_frontend;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done, tx_done;
  logic [6:0] alu_res;
  logic [5:0] da, db, op;
  logic [7:0] tx_data;
  logic       tx_start, err, busy;

  int checks   = 0;
  int failures = 0;
  int m_a = 0, m_b = 0, m_op = 0;
  int ops[8] = '{32, 34, 36, 37, 38, 3, 2, 39};

  always #5 clk = ~clk;

  alu_uart_frontend #(
    .NB_DATA(6), .NB_OP(6), .NB_BYTE(8), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_alu_res(alu_res), .i_tx_done(tx_done),
    .o_data_a(da), .o_data_b(db), .o_op(op), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_err(err), .o_busy(busy)
  );

  function automatic int s6(input int v);
    int t;
    t = v & 63;
    return (t >= 32) ? t - 64 : t;
  endfunction

  // Ideal-precision ALU result on signed 6-bit operands.
  function automatic int alu_int(input int a, input int b, input int o);
    int sa, sb, ub;
    sa = s6(a);
    sb = s6(b);
    ub = b & 63;
    case (o & 63)
      32:      return sa + sb;
      34:      return sa - sb;
      36:      return sa & sb;
      37:      return sa | sb;
      38:      return sa ^ sb;
      39:      return ~(sa | sb);
      3:       return sa >>> ub;
      2:       return (a & 63) >> ub;
      default: return 0;
    endcase
  endfunction

  assign alu_res = 7'(alu_int(int'(da), int'(db), int'(op)));

  function automatic bit legal(input int o);
    return (o & 63) inside {32, 34, 36, 37, 38, 3, 2, 39};
  endfunction

  // 7-bit ALU result wrapped, then sign-extended to a byte.
  function automatic int exp_tx(input int a, input int b, input int o);
    int r;
    r = alu_int(a, b, o) & 127;
    return ((r ^ 64) - 64) & 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                           input int g1, input int g2, input bit poke);
    send_byte(a);
    idle(g1);
    send_byte(b);
    idle(g2);
    send_byte(o);
    if (legal(int'(o))) begin
      m_a  = int'(a) & 63;
      m_b  = int'(b) & 63;
      m_op = int'(o) & 63;
      tick();
      chk("data_a", 32'(da), m_a);
      chk("data_b", 32'(db), m_b);
      chk("op", 32'(op), m_op);
      chk("start_early", 32'(tx_start), 0);
      chk("no_err", 32'(err), 0);
      tick();
      chk("tx_start", 32'(tx_start), 1);
      chk("tx_data", 32'(tx_data), exp_tx(m_a, m_b, m_op));
      tick();
      chk("start_len", 32'(tx_start), 0);
      chk("busy_wait_tx", 32'(busy), 1);
      if (poke) begin
        send_byte(8'h55);
        chk("poke_busy", 32'(busy), 1);
        chk("poke_err", 32'(err), 0);
        chk("poke_start", 32'(tx_start), 0);
      end
      pulse_tx_done();
      chk("busy_done", 32'(busy), 0);
    end else begin
      tick();
      chk("err_pulse", 32'(err), 1);
      chk("bad_start", 32'(tx_start), 0);
      chk("bad_busy", 32'(busy), 0);
      chk("hold_a", 32'(da), m_a);
      chk("hold_b", 32'(db), m_b);
      chk("hold_op", 32'(op), m_op);
      tick();
      chk("err_len", 32'(err), 0);
      chk("bad_start2", 32'(tx_start), 0);
    end
  endtask

  initial begin
    int n;
    logic [7:0] ra, rb, ro;

    rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    idle(2);
    chk("rst_a", 32'(da), 0);
    chk("rst_b", 32'(db), 0);
    chk("rst_op", 32'(op), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 0);
    chk("t1_a", 32'(da), 32'h05);
    chk("t1_b", 32'(db), 32'h03);
    chk("t1_op", 32'(op), 32'h20);
    chk("t1_tx", 32'(tx_data), 32'h08);

    run_frame(8'h02, 8'h05, 8'h22, 1, 2, 0);
    chk("t2_tx", 32'(tx_data), 32'hFD);

    run_frame(8'h01, 8'h02, 8'h3F, 0, 0, 0);
    chk("t3_a", 32'(da), 32'h02);
    chk("t3_op", 32'(op), 32'h22);

    // Stalled frame after one byte.
    send_byte(8'h07);
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_idle_cycles", n, TO);
    chk("t4_busy", 32'(busy), 0);
    tick();
    chk("t4_err_len", 32'(err), 0);
    run_frame(8'h0C, 8'h0A, 8'h24, 0, 0, 0);
    chk("t4_tx", 32'(tx_data), 32'h08);

    // Bytes landing exactly on the expiry cycle are accepted.
    run_frame(8'h09, 8'h11, 8'h20, TO - 1, TO - 1, 0);
    chk("expiry_tx", 32'(tx_data), 32'h1A);

    run_frame(8'h12, 8'h04, 8'h25, 0, 0, 1);
    run_frame(8'h30, 8'h01, 8'h03, 0, 0, 0);
    chk("t5_tx", 32'(tx_data), 32'hF8);

    pulse_tx_done();
    chk("stray_tx_done_busy", 32'(busy), 0);

    send_byte(8'h03);
    send_byte(8'h04);
    rst = 1'b1;
    tick();
    chk("t6_a", 32'(da), 0);
    chk("t6_b", 32'(db), 0);
    chk("t6_op", 32'(op), 0);
    chk("t6_tx", 32'(tx_data), 0);
    chk("t6_busy", 32'(busy), 0);
    rst = 1'b0;
    m_a = 0; m_b = 0; m_op = 0;
    tick();
    chk("t6_err", 32'(err), 0);
    chk("t6_start", 32'(tx_start), 0);
    run_frame(8'h0A, 8'h05, 8'h26, 0, 0, 0);
    chk("t6_tx_after", 32'(tx_data), 32'h0F);

    for (int f = 0; f < 30; f++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ro = 8'(ops[$urandom_range(0, 7)]);
      else                           ro = 8'($urandom_range(0, 255));
      run_frame(ra, rb, ro, int'($urandom_range(0, TO - 1)),
                int'($urandom_range(0, TO - 1)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
